serial_xnor_compare_ctrl: RTL and testbench

- Sequencer that time-shares one external 1-bit XNOR gate (xnorGate) to compare two WIDTH-bit words, one bit per clock, LSB first.
- The block owns the start/busy/done handshake and drives the gate inputs. It samples the gate output, accumulates the match count and records the first mismatch position.
- It sits between a requester issuing compare jobs and a single shared xnorGate instance. This is the team's pattern for sequencing its behavioural gate models.

---
 rtl/serial_xnor_compare_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_xnor_compare_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_xnor_compare_ctrl.sv
// Bit-serial word comparator that drives one shared external XNOR gate, LSB first,
// counting matching bits and recording the lowest mismatching bit position.
module serial_xnor_compare_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             xa,
   output logic             xb,
   input  logic             xc,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic [CW-1:0]    match_count,
   output logic [CW-1:0]    mismatch_pos,
   output logic [1:0]       state_dbg
);

   // Handshake: start is accepted only while busy=0 (IDLE); busy stays high from the
   // cycle after acceptance through the done cycle; done pulses once when results are valid.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CW-1:0] NO_MISMATCH = CW'(WIDTH);
   localparam logic [CW-1:0] LAST_IDX    = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sra_q, sra_d;
   logic [WIDTH-1:0]   srb_q, srb_d;
   logic [CW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      match_count_q, match_count_d;
   logic [CW-1:0]      mismatch_pos_q, mismatch_pos_d;
   logic               equal_q, equal_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [CW-1:0]      count_next;

   always_comb begin
      state_d        = state_q;
      sra_d          = sra_q;
      srb_d          = srb_q;
      idx_d          = idx_q;
      match_count_d  = match_count_q;
      mismatch_pos_d = mismatch_pos_q;
      equal_d        = equal_q;
      done_d         = 1'b0;
      count_next     = match_count_q + CW'(xc);

      case (state_q)
         IDLE: begin
            if (start) begin
               sra_d          = a;
               srb_d          = b;
               idx_d          = '0;
               match_count_d  = '0;
               mismatch_pos_d = NO_MISMATCH;
               equal_d        = 1'b0;
               state_d        = RUN;
            end
         end
         RUN: begin
            match_count_d = count_next;
            if (!xc && (mismatch_pos_q == NO_MISMATCH)) begin
               mismatch_pos_d = idx_q;
            end
            sra_d = sra_q >> 1;
            srb_d = srb_q >> 1;
            idx_d = idx_q + CW'(1);
            // The last gate sample is folded into equal so it is valid with done.
            if (idx_q == LAST_IDX) begin
               equal_d = (count_next == NO_MISMATCH);
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         sra_q          <= '0;
         srb_q          <= '0;
         idx_q          <= '0;
         match_count_q  <= '0;
         mismatch_pos_q <= NO_MISMATCH;
         equal_q        <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         sra_q          <= sra_d;
         srb_q          <= srb_d;
         idx_q          <= idx_d;
         match_count_q  <= match_count_d;
         mismatch_pos_q <= mismatch_pos_d;
         equal_q        <= equal_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
      end
   end

   assign xa           = (state_q == RUN) & sra_q[0];
   assign xb           = (state_q == RUN) & srb_q[0];
   assign busy         = busy_q;
   assign done         = done_q;
   assign equal        = equal_q;
   assign match_count  = match_count_q;
   assign mismatch_pos = mismatch_pos_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_serial_xnor_compare_ctrl.sv
// Directed bench for serial_xnor_compare_ctrl with a behavioural XNOR gate and a
// done-triggered scoreboard holding {equal, match_count, mismatch_pos} per job.
module tb_serial_xnor_compare_ctrl;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam int W     = 1 + 2 * CW;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             xa, xb, xc;
   logic             busy, done, equal;
   logic [CW-1:0]    match_count, mismatch_pos;
   logic [1:0]       state_dbg;

   logic [W-1:0] exp_q[$];
   int n_vec  = 0;
   int n_fail = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   assign xc = ~(xa ^ xb);

   serial_xnor_compare_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .b            (b),
      .xa           (xa),
      .xb           (xb),
      .xc           (xc),
      .busy         (busy),
      .done         (done),
      .equal        (equal),
      .match_count  (match_count),
      .mismatch_pos (mismatch_pos),
      .state_dbg    (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input bit push_exp, input logic e_eq,
                        input logic [CW-1:0] e_mc, input logic [CW-1:0] e_mp);
      @(posedge clk); #1;
      if (push_exp) exp_q.push_back({e_eq, e_mc, e_mp});
      a = ta;
      b = tb_;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Returns the cycle (1-based, counted from the accept edge) in which done is seen.
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("equal", 32'(equal), 32'(e[W-1]));
            check("match_count", 32'(match_count), 32'(e[2*CW-1:CW]));
            check("mismatch_pos", 32'(mismatch_pos), 32'(e[CW-1:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int n_done;
      logic [WIDTH-1:0] seq;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_equal", 32'(equal), 32'd0);
      check("rst_mc", 32'(match_count), 32'd0);
      check("rst_mp", 32'(mismatch_pos), 32'd8);
      check("rst_xa", 32'(xa), 32'd0);
      check("rst_xb", 32'(xb), 32'd0);

      // Equal words, with gate input sequence 1,0,1,0,0,1,0,1 on cycles 1..8
      issue(8'hA5, 8'hA5, 1'b1, 1'b1, 4'd8, 4'd8);
      seq = 8'b1010_0101;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("seq_xa", 32'(xa), 32'(seq[i]));
         check("seq_xb", 32'(xb), 32'(seq[i]));
         check("run_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("done_c9_eq", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_xa", 32'(xa), 32'd0);

      // Single mismatch at bit 2
      issue(8'h0F, 8'h0B, 1'b1, 1'b0, 4'd7, 4'd2);
      wait_done(cyc);
      check("lat_single", 32'(cyc), 32'd9);

      // All bits differ, results held through 5 idle cycles
      issue(8'hFF, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_done(cyc);
      check("lat_alldiff", 32'(cyc), 32'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_busy", 32'(busy), 32'd0);
         check("hold_equal", 32'(equal), 32'd0);
         check("hold_mc", 32'(match_count), 32'd0);
         check("hold_mp", 32'(mismatch_pos), 32'd0);
      end

      // Start pulse during busy is ignored
      issue(8'h01, 8'h03, 1'b1, 1'b0, 4'd7, 4'd1);
      repeat (3) @(posedge clk);
      #1;
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc);
      check("lat_busy_start", 32'(cyc), 32'd5);

      // Start held high: next job accepted in cycle 10, done in cycle 19
      exp_q.push_back({1'b1, 4'd8, 4'd8});
      a = 8'h3C; b = 8'h3C; start = 1'b1;
      @(negedge clk);
      check("gap_busy", 32'(busy), 32'd0);
      check("gap_done", 32'(done), 32'd0);
      wait_done(cyc);
      check("lat_b2b", 32'(cyc), 32'd9);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_idle", 32'(busy), 32'd0);

      // Reset mid-operation abandons the job
      issue(8'h12, 8'h34, 1'b0, 1'b0, 4'd0, 4'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_mc", 32'(match_count), 32'd0);
      check("abort_mp", 32'(mismatch_pos), 32'd8);
      check("abort_equal", 32'(equal), 32'd0);
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);

      issue(8'h12, 8'h34, 1'b1, 1'b0, 4'd5, 4'd1);
      wait_done(cyc);
      check("lat_after_abort", 32'(cyc), 32'd9);

      repeat (3) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
